// File: rtl/grf_pkg.sv
// Shared definitions for the P5 register file and its Decode-side users.
// Holds the register-address width, the hardwired-zero register index and
// the rs/rt instruction field ranges, plus helpers to extract those fields.
package grf_pkg;

  localparam int REG_AW = 5;
  localparam logic [REG_AW-1:0] REG_ZERO = '0;

  // MIPS R/I-format source register fields.
  localparam int RS_HI = 25;
  localparam int RS_LO = 21;
  localparam int RT_HI = 20;
  localparam int RT_LO = 16;

  function automatic logic [REG_AW-1:0] instr_rs(input logic [31:0] instr);
    return instr[RS_HI:RS_LO];
  endfunction

  function automatic logic [REG_AW-1:0] instr_rt(input logic [31:0] instr);
    return instr[RT_HI:RT_LO];
  endfunction

endpackage

// File: rtl/grf_scoreboard.sv
// In-flight writer scoreboard: one saturating counter per register 1..NREG-1.
// Latency: busy flags reflect the registered counters (no same-cycle release).
// No backpressure; over/underflow saturates and raises the sticky err flag.
// Ports: clk/reset; issue+dst claim a register, rel+rel_adr retire a claim;
//        adr1/adr2 select the busy lookups busy1/busy2; err is sticky.
module grf_scoreboard
  import grf_pkg::*;
#(
  parameter int NREG  = 32,
  parameter int CNT_W = 2
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              issue,
  input  logic [REG_AW-1:0] dst,
  input  logic              rel,
  input  logic [REG_AW-1:0] rel_adr,
  input  logic [REG_AW-1:0] adr1,
  input  logic [REG_AW-1:0] adr2,
  output logic              busy1,
  output logic              busy2,
  output logic              err
);

  localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

  logic [CNT_W-1:0] cnt [NREG];

  logic inc;
  logic dec;

  assign inc = issue && (dst != REG_ZERO);
  assign dec = rel && (rel_adr != REG_ZERO);

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < NREG; i++) cnt[i] <= '0;
      err <= 1'b0;
    end else begin
      // Register 0 is never touched, so its counter stays at zero.
      for (int i = 1; i < NREG; i++) begin
        logic inc_i;
        logic dec_i;
        inc_i = inc && (dst == REG_AW'(i));
        dec_i = dec && (rel_adr == REG_AW'(i));
        // A simultaneous claim and release on one register cancel out.
        if (inc_i && !dec_i) begin
          if (cnt[i] == CNT_MAX) err <= 1'b1;
          else                   cnt[i] <= cnt[i] + 1'b1;
        end else if (dec_i && !inc_i) begin
          if (cnt[i] == '0) err <= 1'b1;
          else              cnt[i] <= cnt[i] - 1'b1;
        end
      end
    end
  end

  assign busy1 = (cnt[adr1] != '0);
  assign busy2 = (cnt[adr2] != '0);

endmodule

// File: rtl/grf.sv
// General register file for the P5 pipelined MIPS core.
// Latency: reads are combinational with same-cycle write bypass; log is 1 cycle.
// No backpressure: one write, two reads, one claim and one release per cycle.
// Ports: reg_adr1/2 -> reg_read1/2 (rs/rt); W_we/W_adr/W_data/W_PC write port;
//        D_issue/D_dst claim and W_release retire scoreboard entries (busy1/2,
//        sticky sb_err); log_valid/log_pc/log_adr/log_data record each write.
module grf
  import grf_pkg::*;
#(
  parameter int NREG  = 32,
  parameter int CNT_W = 2
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [REG_AW-1:0] reg_adr1,
  input  logic [REG_AW-1:0] reg_adr2,
  output logic [31:0]       reg_read1,
  output logic [31:0]       reg_read2,
  input  logic              W_we,
  input  logic [REG_AW-1:0] W_adr,
  input  logic [31:0]       W_data,
  input  logic [31:0]       W_PC,
  input  logic              W_release,
  input  logic              D_issue,
  input  logic [REG_AW-1:0] D_dst,
  output logic              busy1,
  output logic              busy2,
  output logic              sb_err,
  output logic              log_valid,
  output logic [31:0]       log_pc,
  output logic [REG_AW-1:0] log_adr,
  output logic [31:0]       log_data
);

  logic [31:0] regs [NREG];
  logic        wr;

  assign wr = W_we && (W_adr != REG_ZERO);

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < NREG; i++) regs[i] <= '0;
    end else if (wr) begin
      regs[W_adr] <= W_data;
    end
  end

  // Bypass the Writeback value so Decode sees it in the same cycle.
  always_comb begin
    reg_read1 = regs[reg_adr1];
    if (reg_adr1 == REG_ZERO)             reg_read1 = '0;
    else if (W_we && W_adr == reg_adr1)   reg_read1 = W_data;
  end

  always_comb begin
    reg_read2 = regs[reg_adr2];
    if (reg_adr2 == REG_ZERO)             reg_read2 = '0;
    else if (W_we && W_adr == reg_adr2)   reg_read2 = W_data;
  end

  // Trace record: payload holds its last value when no write happens.
  always_ff @(posedge clk) begin
    if (reset) begin
      log_valid <= 1'b0;
      log_pc    <= '0;
      log_adr   <= '0;
      log_data  <= '0;
    end else begin
      log_valid <= wr;
      if (wr) begin
        log_pc   <= W_PC;
        log_adr  <= W_adr;
        log_data <= W_data;
      end
    end
  end

  grf_scoreboard #(
    .NREG  (NREG),
    .CNT_W (CNT_W)
  ) u_sb (
    .clk     (clk),
    .reset   (reset),
    .issue   (D_issue),
    .dst     (D_dst),
    .rel     (W_release),
    .rel_adr (W_adr),
    .adr1    (reg_adr1),
    .adr2    (reg_adr2),
    .busy1   (busy1),
    .busy2   (busy2),
    .err     (sb_err)
  );

endmodule

// File: tb/tb_grf.sv
// Scoreboard-style bench for grf: the driver pushes expected values per cycle,
// a negedge monitor pops and compares them against the DUT outputs.
module tb_grf;

  logic        clk = 1'b0;
  logic        reset;
  logic [4:0]  reg_adr1, reg_adr2;
  logic [31:0] reg_read1, reg_read2;
  logic        W_we;
  logic [4:0]  W_adr;
  logic [31:0] W_data, W_PC;
  logic        W_release, D_issue;
  logic [4:0]  D_dst;
  logic        busy1, busy2, sb_err, log_valid;
  logic [31:0] log_pc, log_data;
  logic [4:0]  log_adr;

  grf dut (
    .clk(clk), .reset(reset),
    .reg_adr1(reg_adr1), .reg_adr2(reg_adr2),
    .reg_read1(reg_read1), .reg_read2(reg_read2),
    .W_we(W_we), .W_adr(W_adr), .W_data(W_data), .W_PC(W_PC),
    .W_release(W_release), .D_issue(D_issue), .D_dst(D_dst),
    .busy1(busy1), .busy2(busy2), .sb_err(sb_err),
    .log_valid(log_valid), .log_pc(log_pc), .log_adr(log_adr), .log_data(log_data)
  );

  always #5 clk = ~clk;

  localparam int T_RD1 = 0, T_RD2 = 1, T_BUSY1 = 2, T_BUSY2 = 3, T_ERR = 4, T_LOGV = 5;

  typedef struct {
    int          tag;
    logic [31:0] exp;
  } item_t;

  typedef struct {
    int          due;
    logic [31:0] pc;
    logic [4:0]  adr;
    logic [31:0] data;
  } log_t;

  item_t  exp_q[$];
  string  name_q[$];
  log_t   log_q[$];

  int n_cmp = 0;
  int n_bad = 0;
  int cyc_n = 0;

  task automatic expect_val(input int tag, input logic [31:0] v, input string nm);
    item_t it;
    it.tag = tag;
    it.exp = v;
    exp_q.push_back(it);
    name_q.push_back(nm);
  endtask

  task automatic expect_log(input logic [31:0] pc, input logic [4:0] adr, input logic [31:0] data);
    log_t l;
    l.due  = cyc_n + 1;
    l.pc   = pc;
    l.adr  = adr;
    l.data = data;
    log_q.push_back(l);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
    cyc_n++;
  endtask

  task automatic idle();
    reset = 1'b0; W_we = 1'b0; W_adr = '0; W_data = '0; W_PC = '0;
    W_release = 1'b0; D_issue = 1'b0; D_dst = '0;
  endtask

  // Monitor: compares queued expectations and the write log at each negedge.
  initial begin
    forever begin
      @(negedge clk);
      while (exp_q.size() > 0) begin
        item_t       it;
        string       nm;
        logic [31:0] act;
        it = exp_q.pop_front();
        nm = name_q.pop_front();
        case (it.tag)
          T_RD1:   act = reg_read1;
          T_RD2:   act = reg_read2;
          T_BUSY1: act = {31'b0, busy1};
          T_BUSY2: act = {31'b0, busy2};
          T_ERR:   act = {31'b0, sb_err};
          default: act = {31'b0, log_valid};
        endcase
        n_cmp++;
        if (act !== it.exp) begin
          n_bad++;
          $display("FAIL %s (cycle %0d): got %h expected %h", nm, cyc_n, act, it.exp);
        end
      end
      if (log_q.size() > 0 && log_q[0].due == cyc_n) begin
        log_t l;
        l = log_q.pop_front();
        n_cmp++;
        if (log_valid !== 1'b1 || log_pc !== l.pc || log_adr !== l.adr || log_data !== l.data) begin
          n_bad++;
          $display("FAIL log_record (cycle %0d): got v=%b pc=%h adr=%0d data=%h expected v=1 pc=%h adr=%0d data=%h",
                   cyc_n, log_valid, log_pc, log_adr, log_data, l.pc, l.adr, l.data);
        end
      end else if (log_valid === 1'b1) begin
        n_cmp++;
        n_bad++;
        $display("FAIL log_unexpected (cycle %0d): got log_valid=1 expected 0", cyc_n);
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    n_bad++;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $fatal(1, "watchdog");
  end

  initial begin
    idle();
    reg_adr1 = '0; reg_adr2 = '0;
    reset = 1'b1;
    tick();                       // reset edge has occurred
    reset = 1'b0;
    expect_val(T_ERR, 0, "reset_sb_err");
    expect_val(T_LOGV, 0, "reset_log_valid");
    for (int a = 0; a < 32; a++) begin
      if (a > 0) tick();
      reg_adr1 = 5'(a);
      reg_adr2 = 5'(31 - a);
      expect_val(T_RD1, 0, "reset_read1");
      expect_val(T_RD2, 0, "reset_read2");
      expect_val(T_BUSY1, 0, "reset_busy1");
      expect_val(T_BUSY2, 0, "reset_busy2");
    end

    // Write then read, with bypass in the write cycle.
    tick();
    W_we = 1'b1; W_adr = 5'd5; W_data = 32'h1234_5678; W_PC = 32'h0000_3000;
    reg_adr1 = 5'd5; reg_adr2 = 5'd6;
    expect_val(T_RD1, 32'h1234_5678, "bypass_read1");
    expect_val(T_RD2, 0, "bypass_other_port");
    expect_log(32'h0000_3000, 5'd5, 32'h1234_5678);
    tick();
    idle();
    expect_val(T_RD1, 32'h1234_5678, "stored_read1");

    // Same address on both ports, bypass and then storage.
    tick();
    W_we = 1'b1; W_adr = 5'd7; W_data = 32'hCAFE_F00D; W_PC = 32'h0000_3004;
    reg_adr1 = 5'd7; reg_adr2 = 5'd7;
    expect_val(T_RD1, 32'hCAFE_F00D, "dual_bypass1");
    expect_val(T_RD2, 32'hCAFE_F00D, "dual_bypass2");
    expect_log(32'h0000_3004, 5'd7, 32'hCAFE_F00D);
    tick();
    idle();
    expect_val(T_RD1, 32'hCAFE_F00D, "dual_stored1");
    expect_val(T_RD2, 32'hCAFE_F00D, "dual_stored2");

    // Register 0 ignores writes and claims.
    tick();
    W_we = 1'b1; W_adr = 5'd0; W_data = 32'hFFFF_FFFF; W_PC = 32'h0000_3008;
    D_issue = 1'b1; D_dst = 5'd0;
    reg_adr1 = 5'd0; reg_adr2 = 5'd0;
    expect_val(T_RD1, 0, "r0_read1_wcycle");
    expect_val(T_RD2, 0, "r0_read2_wcycle");
    tick();
    idle();
    expect_val(T_RD1, 0, "r0_read1_after");
    expect_val(T_RD2, 0, "r0_read2_after");
    expect_val(T_LOGV, 0, "r0_log_valid");
    expect_val(T_BUSY1, 0, "r0_busy1");
    expect_val(T_ERR, 0, "r0_no_err");

    // Scoreboard sequence on register 8 (register 10 runs alongside).
    reg_adr1 = 5'd8; reg_adr2 = 5'd10;
    tick(); D_issue = 1'b1; D_dst = 5'd8;
    expect_val(T_BUSY1, 0, "r8_busy_before");
    tick(); D_issue = 1'b1; D_dst = 5'd8;
    expect_val(T_BUSY1, 1, "r8_busy_cnt1");
    tick(); D_issue = 1'b1; D_dst = 5'd8; W_release = 1'b1; W_adr = 5'd8;
    expect_val(T_BUSY1, 1, "r8_busy_cnt2");
    tick(); D_issue = 1'b1; D_dst = 5'd10; W_release = 1'b1; W_adr = 5'd8;
    expect_val(T_BUSY1, 1, "r8_busy_after_both");
    expect_val(T_BUSY2, 0, "r10_busy_before");
    tick(); idle(); W_release = 1'b1; W_adr = 5'd8;
    expect_val(T_BUSY1, 1, "r8_busy_cnt1_again");
    expect_val(T_BUSY2, 1, "r10_busy_independent");
    // Release still pending this cycle: busy stays registered.
    tick(); idle(); W_release = 1'b1; W_adr = 5'd10;
    expect_val(T_BUSY1, 0, "r8_busy_cleared");
    expect_val(T_BUSY2, 1, "r10_busy_same_cycle_release");
    expect_val(T_ERR, 0, "r8_err_before_underflow");
    tick(); idle(); W_release = 1'b1; W_adr = 5'd8;
    expect_val(T_BUSY2, 0, "r10_busy_cleared");
    expect_val(T_ERR, 0, "err_still_clear");
    tick(); idle();
    expect_val(T_ERR, 1, "underflow_err");
    expect_val(T_BUSY1, 0, "r8_underflow_holds0");
    tick();
    expect_val(T_ERR, 1, "underflow_err_sticky");

    // Overflow on register 9 after a clearing reset.
    tick(); reset = 1'b1;
    tick(); reset = 1'b0;
    reg_adr1 = 5'd9;
    expect_val(T_ERR, 0, "reset_clears_err");
    for (int k = 0; k < 4; k++) begin
      if (k > 0) tick();
      D_issue = 1'b1; D_dst = 5'd9;
      expect_val(T_ERR, 0, "ovf_err_before_4th");
    end
    tick(); idle();
    expect_val(T_ERR, 1, "ovf_err");
    expect_val(T_BUSY1, 1, "ovf_saturated_busy");
    tick(); reset = 1'b1;
    tick(); reset = 1'b0;
    expect_val(T_ERR, 0, "ovf_reset_err");
    expect_val(T_BUSY1, 0, "ovf_reset_busy");

    // Mid-stream reset discards claims and the concurrent write.
    reg_adr1 = 5'd3; reg_adr2 = 5'd4;
    tick(); D_issue = 1'b1; D_dst = 5'd3;
    tick(); D_issue = 1'b1; D_dst = 5'd4;
    expect_val(T_BUSY1, 1, "mid_busy3_claimed");
    tick(); reset = 1'b1; D_issue = 1'b0;
    W_we = 1'b1; W_adr = 5'd3; W_data = 32'h0000_ABCD; W_PC = 32'h0000_3010;
    expect_val(T_BUSY1, 1, "mid_busy3_pre");
    expect_val(T_BUSY2, 1, "mid_busy4_pre");
    expect_val(T_RD1, 32'h0000_ABCD, "mid_bypass_during_reset");
    tick(); idle();
    expect_val(T_RD1, 0, "mid_r3_cleared");
    expect_val(T_BUSY1, 0, "mid_busy3_cleared");
    expect_val(T_BUSY2, 0, "mid_busy4_cleared");
    expect_val(T_LOGV, 0, "mid_log_valid");

    tick();
    tick();
    @(negedge clk);
    #1;
    n_cmp++;
    if (log_q.size() != 0 || exp_q.size() != 0) begin
      n_bad++;
      $display("FAIL drain: got %0d log / %0d items pending expected 0 / 0", log_q.size(), exp_q.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/grf.md
Name: grf

Overview:
- General register file for the P5 pipelined MIPS core. It answers the Decode stage's two combinational read ports (rs/rt).
- It accepts the single Writeback-stage write port, with write-to-read bypass inside the same cycle.
- It keeps a per-register in-flight-writer scoreboard: Decode claims a destination on issue, Writeback releases it, and busy flags flag pending producers.
- It emits a registered write-log record for the reference-trace checker.

Parameters:
- NREG, 32, number of architectural registers; register 0 is hardwired to zero.
- CNT_W, 2, width of each scoreboard counter; maximum in-flight writers per register is 2^CNT_W-1 = 3.

Ports:
- clk  in  1  clock.
- reset  in  1  synchronous, active-high reset.
- reg_adr1  in  5  read address port 1 (rs).
- reg_adr2  in  5  read address port 2 (rt).
- reg_read1  out  32  read data port 1.
- reg_read2  out  32  read data port 2.
- W_we  in  1  Writeback write enable.
- W_adr  in  5  write address.
- W_data  in  32  write data.
- W_PC  in  32  PC of the writing instruction, used only for logging.
- W_release  in  1  Writeback retires an instruction that holds a claim on W_adr.
- D_issue  in  1  Decode issues an instruction that will write D_dst.
- D_dst  in  5  destination claimed on issue.
- busy1  out  1  reg_adr1 has at least one in-flight writer.
- busy2  out  1  reg_adr2 has at least one in-flight writer.
- sb_err  out  1  sticky scoreboard overflow/underflow flag.
- log_valid  out  1  registered: a write occurred last cycle.
- log_pc  out  32  registered PC of that write.
- log_adr  out  5  registered address of that write.
- log_data  out  32  registered data of that write.

Behaviour:

Reset (synchronous, takes precedence over every other input on that edge):
- All 32 registers become 0.
- All scoreboard counters become 0.
- sb_err = 0, log_valid = 0, log_pc/log_adr/log_data = 0.
- A reset asserted in mid-stream discards all pending claims.

Storage:
- On posedge clk, if W_we && W_adr != 0, then regs[W_adr] <= W_data.
- Writes to register 0 are dropped.

Reads (combinational, zero latency):
- reg_readN = 0 if reg_adrN == 0.
- Otherwise reg_readN = W_data if W_we && W_adr == reg_adrN (bypass).
- Otherwise reg_readN = regs[reg_adrN].
- Both ports are independent; identical addresses return identical data.

Scoreboard (one counter per register 1..31; register 0 is never tracked and its busy is always 0):
- inc = D_issue && D_dst != 0.
- dec = W_release && W_adr != 0.
- Different registers: each counter updates independently, +1 and -1 respectively.
- Same register with inc && dec: the counter is unchanged.
- inc on a counter already at 3: counter holds at 3, sb_err <= 1.
- dec on a counter already at 0: counter holds at 0, sb_err <= 1.
- sb_err is sticky until reset.
- busyN = (cnt[reg_adrN] != 0), taken from the registered counter value.
- A release in the current cycle does NOT clear busy combinationally. The data bypass already covers that case, and the hazard unit combines the two.
- W_release does not require W_we. A non-writing retire of a claim is legal, e.g. a cancelled link.

Write log:
- On posedge clk: log_valid <= W_we && W_adr != 0.
- On the same condition, log_pc/log_adr/log_data capture W_PC/W_adr/W_data; otherwise they hold their previous values.
- Latency is exactly 1 cycle after the write edge.

Decomposition:
- Shared macros file holds: register-address width 5, register 0 index, and the _rs/_rt field ranges already used by Decode.
- One natural sub-module, grf_scoreboard: the counters, the busy lookup and sb_err.
- The storage, bypass and log stay in grf.

Test Plan:
- Reset check: with reset high for one cycle, read every address -> all reads 0, busy1/2 = 0, log_valid = 0, sb_err = 0.
- Write then read: W_we = 1, W_adr = 5, W_data = 0x1234_5678, W_PC = 0x3000 -> in the same cycle reg_adr1 = 5 reads 0x1234_5678 via bypass. Next cycle it still reads 0x1234_5678 from storage, and log_valid = 1, log_pc = 0x3000, log_adr = 5, log_data = 0x1234_5678.
- Register 0: write 0xFFFF_FFFF to address 0, plus D_issue with D_dst = 0 -> reg_read1/2 at address 0 stay 0, log_valid = 0, and busy stays 0 when reading address 0.
- Scoreboard sequence on register 8:
  - Issue twice -> busy = 1, counter = 2.
  - Issue and release in the same cycle -> counter stays 2.
  - Two releases -> busy = 0.
  - One more release -> sb_err = 1 and stays 1 until reset.
- Overflow: four back-to-back issues to register 9 with no release -> counter saturates at 3, sb_err = 1 after the 4th edge; a subsequent reset clears both.
- Mid-stream reset: claims outstanding on registers 3 and 4 plus a concurrent write to register 3 with reset high -> after the edge, register 3 = 0, busy = 0 for both, log_valid = 0.
